cpu_run_controller: RTL and testbench
=====================================

// Module: cpu_run_controller
// PURPOSE
//   Sequences the cpu core by generating its single-cycle 'enable' strobe. Supports halt,
//   free-run at a slow or turbo rate, single-step, and one hardware breakpoint on the
//   instruction pointer. Sits between the board button/switch logic and the cpu 'enable'
//   input. Counts retired instructions for the display.
// PARAMETERS
//   DIV_WIDTH  24          prescaler counter width
//   SLOW_DIV   12_000_000  clocks per instruction when turbo=0 (must be >=2 and < 2**DIV_WIDTH)
//   FAST_DIV   12_000      clocks per instruction when turbo=1 (must be >=2 and < 2**DIV_WIDTH)
// PORTS
//   clk                 in   1   system clock
//   reset               in   1   asynchronous reset, active-high
//   run_req             in   1   1-cycle pulse: toggles run/halt
//   step_req            in   1   1-cycle pulse: execute one instruction while halted
//   turbo               in   1   level: 1 selects FAST_DIV, 0 selects SLOW_DIV
//   bp_enable           in   1   level: breakpoint armed
//   bp_addr             in   8   breakpoint instruction address
//   instruction_pointer in   8   current cpu instruction pointer
//   cpu_enable          out  1   registered strobe to cpu 'enable'
//   state               out  2   0=HALT 1=RUN 2=STEP 3=BREAK
//   bp_hit              out  1   registered 1-cycle pulse on breakpoint entry
//   retire_count        out  16  number of cpu_enable strobes issued
// BEHAVIOUR
//   Reset: state=HALT, cpu_enable=0, bp_hit=0, retire_count=0, prescaler=0, skip_bp=0.
//   Reset is asynchronous and takes effect immediately, including mid-RUN or mid-STEP.
//   Every output is registered. All transitions occur on the clk rising edge.
//   HALT or BREAK:
//     run_req  -> RUN, prescaler<=0, skip_bp<=1.
//     step_req -> STEP, cpu_enable<=1.
//     If both are asserted in the same cycle, run_req wins and step_req is dropped.
//   STEP: the next edge sets state<=HALT and cpu_enable<=0. STEP lasts exactly one cycle.
//     It never checks the breakpoint. run_req and step_req are ignored while in STEP.
//   RUN:
//     div = turbo ? FAST_DIV : SLOW_DIV. div is re-evaluated every cycle.
//     On an edge where prescaler >= div-1: prescaler<=0, and then:
//       - If bp_enable && instruction_pointer==bp_addr && !skip_bp: state<=BREAK,
//         bp_hit<=1, and no strobe is issued.
//       - Otherwise: cpu_enable<=1 for one cycle, and skip_bp<=0.
//     On any other edge: prescaler<=prescaler+1 and cpu_enable<=0.
//     Using >= means that switching turbo to a smaller div mid-count fires on the next edge.
//     run_req -> HALT, prescaler<=0, cpu_enable<=0. This takes priority over a strobe in
//       the same cycle. step_req is ignored in RUN.
//   skip_bp ensures that resuming from a breakpoint executes the breakpointed instruction
//   instead of re-trapping on it.
//   The cpu updates instruction_pointer on the edge after the strobe. The breakpoint
//   compare therefore always sees the address of the instruction about to execute.
//   Strobes are at least 2 cycles apart, so the cpu never sees back-to-back enables.
//   retire_count increments on every edge where cpu_enable is 1. It wraps 16'hFFFF -> 0.
//   bp_hit is 0 in every cycle except the cycle after BREAK entry.
// TESTING (bench overrides SLOW_DIV=10 and FAST_DIV=4)
//   1. Reset; pulse step_req at cycle 5 -> cpu_enable=1 in cycle 6 only, state STEP->HALT,
//      retire_count=1.
//   2. turbo=1; pulse run_req -> strobes every 4 cycles. Set turbo=0 -> strobes every 10
//      cycles. Pulse run_req -> HALT with no further strobes.
//   3. bp_enable=1, bp_addr=8'h03; run from ip=0, with the model ip incremented on each
//      strobe -> 3 strobes, then BREAK with a 1-cycle bp_hit and retire_count=3.
//   4. From the test-3 BREAK state, pulse run_req -> the first strobe is issued at ip=3
//      without re-trap, and the run continues.
//   5. In HALT, pulse run_req and step_req in the same cycle -> RUN and no STEP strobe.
//      retire_count is then preloaded to 16'hFFFF and one more strobe is issued -> it wraps to 0.
//   6. Assert reset mid-RUN for 1 cycle, asynchronously -> all outputs return to reset values
//      immediately, and no strobe is issued after deassertion until run_req or step_req.

Source files
------------

// File: rtl/cpu_run_controller.sv
// cpu_run_controller
// Generates the single-cycle 'enable' strobe that paces the cpu core.
// Supports halt, free-run at a slow or turbo rate, single-step, and one
// hardware breakpoint on the instruction pointer. Also counts the
// instructions retired, for the display.

module cpu_run_controller #(
  parameter int DIV_WIDTH = 24,
  parameter int SLOW_DIV  = 12_000_000,
  parameter int FAST_DIV  = 12_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run_req,
  input  logic       step_req,
  input  logic       turbo,
  input  logic       bp_enable,
  input  logic [7:0] bp_addr,
  input  logic [7:0] instruction_pointer,
  output logic       cpu_enable,
  output logic [1:0] state,
  output logic       bp_hit,
  output logic [15:0] retire_count
);

  // The prescaler fires when it reaches div-1. These are the terminal counts.
  localparam logic [DIV_WIDTH-1:0] SLOW_LAST = DIV_WIDTH'(SLOW_DIV - 1);
  localparam logic [DIV_WIDTH-1:0] FAST_LAST = DIV_WIDTH'(FAST_DIV - 1);
  localparam logic [DIV_WIDTH-1:0] PRESC_ZERO = {DIV_WIDTH{1'b0}};
  localparam logic [DIV_WIDTH-1:0] PRESC_ONE  = DIV_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_HALT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STEP  = 2'd2,
    ST_BREAK = 2'd3
  } run_state_t;

  run_state_t           cur_state;
  run_state_t           nxt_state;
  logic [DIV_WIDTH-1:0] prescaler;
  logic [DIV_WIDTH-1:0] nxt_prescaler;
  logic                 skip_bp;
  logic                 nxt_skip_bp;
  logic                 nxt_cpu_enable;
  logic                 nxt_bp_hit;
  logic [DIV_WIDTH-1:0] div_last;
  logic                 div_done;
  logic                 bp_match;

  assign state = cur_state;

  // Rate selection is re-evaluated every cycle. Using >= means that a switch
  // to a shorter period mid-count fires on the next edge instead of wrapping.
  assign div_last = turbo ? FAST_LAST : SLOW_LAST;
  assign div_done = (prescaler >= div_last);

  // skip_bp masks the trap for the first instruction after a resume, so
  // the breakpointed instruction itself executes.
  assign bp_match = bp_enable && (instruction_pointer == bp_addr) && !skip_bp;

  // Next-state and next-output logic for the run/halt/step/break sequencer.
  always_comb begin
    nxt_state      = cur_state;
    nxt_prescaler  = prescaler;
    nxt_skip_bp    = skip_bp;
    nxt_cpu_enable = 1'b0;
    nxt_bp_hit     = 1'b0;

    case (cur_state)
      ST_HALT, ST_BREAK: begin
        // run_req wins over step_req when both arrive together.
        if (run_req) begin
          nxt_state     = ST_RUN;
          nxt_prescaler = PRESC_ZERO;
          nxt_skip_bp   = 1'b1;
        end else if (step_req) begin
          nxt_state      = ST_STEP;
          nxt_cpu_enable = 1'b1;
        end else begin
          nxt_state = cur_state;
        end
      end

      ST_STEP: begin
        // The strobe was issued on entry. Return to HALT after one cycle,
        // ignoring requests and the breakpoint.
        nxt_state = ST_HALT;
      end

      ST_RUN: begin
        if (run_req) begin
          // A halt request beats a strobe due in the same cycle.
          nxt_state     = ST_HALT;
          nxt_prescaler = PRESC_ZERO;
        end else if (div_done) begin
          nxt_prescaler = PRESC_ZERO;
          if (bp_match) begin
            nxt_state  = ST_BREAK;
            nxt_bp_hit = 1'b1;
          end else begin
            nxt_cpu_enable = 1'b1;
            nxt_skip_bp    = 1'b0;
          end
        end else begin
          nxt_prescaler = prescaler + PRESC_ONE;
        end
      end

      default: begin
        nxt_state     = ST_HALT;
        nxt_prescaler = PRESC_ZERO;
      end
    endcase
  end

  // Sequencer state, prescaler and registered strobe outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_state  <= ST_HALT;
      prescaler  <= PRESC_ZERO;
      skip_bp    <= 1'b0;
      cpu_enable <= 1'b0;
      bp_hit     <= 1'b0;
    end else begin
      cur_state  <= nxt_state;
      prescaler  <= nxt_prescaler;
      skip_bp    <= nxt_skip_bp;
      cpu_enable <= nxt_cpu_enable;
      bp_hit     <= nxt_bp_hit;
    end
  end

  // Retired-instruction counter. It advances once per issued strobe and wraps naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retire_count <= 16'h0000;
    end else if (cpu_enable) begin
      retire_count <= retire_count + 16'd1;
    end else begin
      retire_count <= retire_count;
    end
  end

endmodule

// File: tb/tb_cpu_run_controller.sv
// Testbench for cpu_run_controller. The expected strobe cycles are queued as
// stimulus is applied, and they are popped as strobes are observed.

module tb_cpu_run_controller;

  logic        clk;
  logic        reset;
  logic        run_req;
  logic        step_req;
  logic        turbo;
  logic        bp_enable;
  logic [7:0]  bp_addr;
  logic [7:0]  instruction_pointer;
  logic        cpu_enable;
  logic [1:0]  state;
  logic        bp_hit;
  logic [15:0] retire_count;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int exp_q[$];

  cpu_run_controller #(
    .DIV_WIDTH(24),
    .SLOW_DIV (10),
    .FAST_DIV (4)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .run_req            (run_req),
    .step_req           (step_req),
    .turbo              (turbo),
    .bp_enable          (bp_enable),
    .bp_addr            (bp_addr),
    .instruction_pointer(instruction_pointer),
    .cpu_enable         (cpu_enable),
    .state              (state),
    .bp_hit             (bp_hit),
    .retire_count       (retire_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running cycle index, which is sampled at negedges.
  always @(posedge clk) cyc <= cyc + 1;

  // Wait for the next strobe, compare its cycle with the queued expectation,
  // then advance the modelled instruction pointer the way the cpu would.
  task automatic wait_strobe(input string tag, input int budget);
    int seen_at;
    int want;
    seen_at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (cpu_enable === 1'b1) begin
        seen_at = cyc;
        break;
      end
    end
    want = (exp_q.size() > 0) ? exp_q.pop_front() : -2;
    total++;
    if (seen_at !== want) begin
      bad++;
      $display("FAIL %s strobe cycle: got %0d want %0d", tag, seen_at, want);
    end
    if (seen_at >= 0) instruction_pointer = instruction_pointer + 8'd1;
  endtask

  task automatic quiet(input string tag, input int n);
    int seen;
    seen = 0;
    repeat (n) begin
      @(negedge clk);
      if (cpu_enable !== 1'b0) seen++;
    end
    total++;
    if (seen !== 0) begin
      bad++;
      $display("FAIL %s quiet: got %0d strobes want 0", tag, seen);
    end
  endtask

  task automatic pulse_run();
    run_req = 1'b1;
    @(negedge clk);
    run_req = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    run_req = 1'b0; step_req = 1'b0; turbo = 1'b0;
    bp_enable = 1'b0; bp_addr = 8'h00; instruction_pointer = 8'h00;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({state, cpu_enable, bp_hit, retire_count} !== {2'd0, 1'b0, 1'b0, 16'h0000}) begin
      bad++;
      $display("FAIL reset_state: got st=%0d en=%0b hit=%0b rc=%0h want 0/0/0/0",
               state, cpu_enable, bp_hit, retire_count);
    end
    reset = 1'b0;
  endtask

  task automatic test_step();
    int c;
    repeat (4) @(negedge clk);
    step_req = 1'b1;
    c = cyc;
    exp_q.push_back(c + 1);
    @(negedge clk);
    step_req = 1'b0;
    total++;
    if (state !== 2'd2 || cpu_enable !== 1'b1) begin
      bad++;
      $display("FAIL step_entry: got st=%0d en=%0b want 2/1", state, cpu_enable);
    end
    total++;
    if (cyc !== exp_q.pop_front()) begin
      bad++;
      $display("FAIL step_cycle: got %0d want %0d", cyc, c + 1);
    end
    @(negedge clk);
    total++;
    if (state !== 2'd0 || cpu_enable !== 1'b0 || retire_count !== 16'd1) begin
      bad++;
      $display("FAIL step_exit: got st=%0d en=%0b rc=%0d want 0/0/1", state, cpu_enable, retire_count);
    end
    quiet("step_after", 12);
  endtask

  task automatic test_rates();
    int c;
    int s;
    turbo = 1'b1;
    c = cyc;
    for (int k = 1; k <= 3; k++) exp_q.push_back(c + 1 + 4 * k);
    pulse_run();
    total++;
    if (state !== 2'd1) begin
      bad++;
      $display("FAIL run_entry: got st=%0d want 1", state);
    end
    for (int k = 0; k < 3; k++) wait_strobe("turbo", 20);
    s = cyc;
    turbo = 1'b0;
    exp_q.push_back(s + 10);
    exp_q.push_back(s + 20);
    wait_strobe("slow_a", 30);
    wait_strobe("slow_b", 30);
    pulse_run();
    total++;
    if (state !== 2'd0) begin
      bad++;
      $display("FAIL run_halt: got st=%0d want 0", state);
    end
    quiet("halted", 30);
  endtask

  task automatic test_breakpoint();
    int c;
    apply_reset();
    turbo = 1'b1;
    bp_enable = 1'b1;
    bp_addr = 8'h03;
    instruction_pointer = 8'h00;
    c = cyc;
    for (int k = 1; k <= 3; k++) exp_q.push_back(c + 1 + 4 * k);
    pulse_run();
    for (int k = 0; k < 3; k++) wait_strobe("bp_run", 20);
    repeat (4) @(negedge clk);
    total++;
    if (state !== 2'd3 || bp_hit !== 1'b1 || cpu_enable !== 1'b0 || retire_count !== 16'd3) begin
      bad++;
      $display("FAIL bp_entry: got st=%0d hit=%0b en=%0b rc=%0d want 3/1/0/3",
               state, bp_hit, cpu_enable, retire_count);
    end
    @(negedge clk);
    total++;
    if (bp_hit !== 1'b0 || state !== 2'd3) begin
      bad++;
      $display("FAIL bp_pulse: got hit=%0b st=%0d want 0/3", bp_hit, state);
    end
    quiet("in_break", 20);
  endtask

  task automatic test_resume();
    int c;
    c = cyc;
    exp_q.push_back(c + 5);
    exp_q.push_back(c + 9);
    pulse_run();
    wait_strobe("resume_first", 20);
    wait_strobe("resume_next", 20);
    @(negedge clk);
    total++;
    if (state !== 2'd1 || retire_count !== 16'd5 || bp_hit !== 1'b0) begin
      bad++;
      $display("FAIL resume: got st=%0d rc=%0d hit=%0b want 1/5/0", state, retire_count, bp_hit);
    end
    pulse_run();
    total++;
    if (state !== 2'd0) begin
      bad++;
      $display("FAIL resume_halt: got st=%0d want 0", state);
    end
  endtask

  task automatic test_back_to_back();
    int c;
    bp_enable = 1'b0;
    turbo = 1'b1;
    repeat (2) @(negedge clk);
    run_req = 1'b1;
    step_req = 1'b1;
    c = cyc;
    exp_q.push_back(c + 5);
    @(negedge clk);
    run_req = 1'b0;
    step_req = 1'b0;
    total++;
    if (state !== 2'd1 || cpu_enable !== 1'b0) begin
      bad++;
      $display("FAIL run_step_same: got st=%0d en=%0b want 1/0", state, cpu_enable);
    end
    force dut.retire_count = 16'hFFFF;
    #1;
    release dut.retire_count;
    wait_strobe("wrap_strobe", 20);
    total++;
    if (retire_count !== 16'hFFFF) begin
      bad++;
      $display("FAIL preload: got %0h want ffff", retire_count);
    end
    @(negedge clk);
    total++;
    if (retire_count !== 16'h0000) begin
      bad++;
      $display("FAIL wrap: got %0h want 0", retire_count);
    end
    pulse_run();
  endtask

  task automatic test_async_reset();
    int c;
    turbo = 1'b1;
    c = cyc;
    exp_q.push_back(c + 5);
    pulse_run();
    wait_strobe("pre_reset", 20);
    #2;
    reset = 1'b1;
    #1;
    total++;
    if ({state, cpu_enable, bp_hit, retire_count} !== {2'd0, 1'b0, 1'b0, 16'h0000}) begin
      bad++;
      $display("FAIL async_reset: got st=%0d en=%0b hit=%0b rc=%0h want 0/0/0/0",
               state, cpu_enable, bp_hit, retire_count);
    end
    @(negedge clk);
    reset = 1'b0;
    quiet("post_reset", 30);
    total++;
    if (state !== 2'd0 || retire_count !== 16'h0000) begin
      bad++;
      $display("FAIL post_reset_state: got st=%0d rc=%0h want 0/0", state, retire_count);
    end
  endtask

  initial begin
    test_reset();
    test_step();
    test_rates();
    test_breakpoint();
    test_resume();
    test_back_to_back();
    test_async_reset();
    total++;
    if (exp_q.size() !== 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
